// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator core: key codes, FSM states, operators.
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_EQUAL = 4'd13;
  localparam logic [3:0] KEY_CLEAR = 4'd14;
  localparam logic [3:0] KEY_BKSP  = 4'd15;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    CALC    = 3'd2,
    CONV    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  function automatic int clog2(input longint value);
    int     r;
    longint v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one bit per cycle, W cycles; first step happens on the start cycle.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int W    = 14,
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [W-1:0]      bin,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);
  localparam int DW = 4 * NDIG;
  localparam int CW = clog2(W + 1);

  logic [W-1:0]  bin_reg;
  logic [DW-1:0] bcd_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  src_bin;
  logic [DW-1:0] src_bcd;
  logic [DW-1:0] adj;

  // Start loads the operand and performs the first step in the same cycle.
  assign src_bin = start ? bin : bin_reg;
  assign src_bcd = start ? '0 : bcd_reg;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (src_bcd[4*gi +: 4] >= 4'd5) ? src_bcd[4*gi +: 4] + 4'd3
                                                            : src_bcd[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      cnt_reg <= '0;
    end else if (abort) begin
      cnt_reg <= '0;
    end else if (start) begin
      bcd_reg <= DW'({adj, src_bin[W-1]});
      bin_reg <= src_bin << 1;
      cnt_reg <= CW'(W - 1);
    end else if (cnt_reg != '0) begin
      bcd_reg <= DW'({adj, src_bin[W-1]});
      bin_reg <= src_bin << 1;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == CW'(1)) && !abort;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/bcd_calc_engine.sv
// Multi-digit keypad calculator core: operand entry, add/sub/shift-add multiply, BCD result display.
module bcd_calc_engine
  import calc_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              busy,
  output logic [4*NDIG-1:0] disp_bcd,
  output logic              disp_neg,
  output logic              overflow,
  output logic              result_valid,
  output logic [1:0]        op_ind
);
  localparam int W  = clog2(10 ** NDIG);
  localparam int DW = 4 * NDIG;
  localparam int CW = clog2(W + 1);
  localparam logic [2*W-1:0] LIMIT = (2*W)'(10 ** NDIG);

  state_t        state_reg;
  op_t           op_reg;
  logic [DW-1:0] a_bcd_reg, b_bcd_reg;
  logic [W-1:0]  a_bin_reg, b_bin_reg;
  logic [2*W-1:0] acc_reg, mcand_reg;
  logic [W-1:0]  mplier_reg;
  logic [CW-1:0] cnt_reg;
  logic          neg_reg, ovf_reg, rv_reg, conv_first_reg;

  logic key_digit, key_op, key_eq, key_clr, key_bksp;
  logic [DW-1:0]  cur_bcd, ed_bcd, conv_bcd;
  logic [W-1:0]   cur_bin, ed_bin;
  logic [2*W-1:0] mul_add, sum_res, diff_res;
  logic           is_ovf, conv_start, conv_done;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_MUL);
  assign key_eq    = key_valid && (key_code == KEY_EQUAL);
  assign key_clr   = key_valid && (key_code == KEY_CLEAR);
  assign key_bksp  = key_valid && (key_code == KEY_BKSP);

  // Shared edit path for whichever operand is being entered; a full operand ignores digits.
  always_comb begin
    cur_bcd = (state_reg == ENTER_B) ? b_bcd_reg : a_bcd_reg;
    cur_bin = (state_reg == ENTER_B) ? b_bin_reg : a_bin_reg;
    ed_bcd  = cur_bcd;
    ed_bin  = cur_bin;
    if (key_digit && (cur_bcd[DW-1 -: 4] == 4'd0)) begin
      ed_bcd = (cur_bcd << 4) | DW'(key_code);
      ed_bin = cur_bin * W'(10) + W'(key_code);
    end else if (key_bksp) begin
      ed_bcd = cur_bcd >> 4;
      ed_bin = cur_bin / W'(10);
    end
  end

  assign mul_add  = mplier_reg[0] ? mcand_reg : '0;
  assign sum_res  = (2*W)'(a_bin_reg) + (2*W)'(b_bin_reg);
  assign diff_res = (a_bin_reg >= b_bin_reg) ? (2*W)'(a_bin_reg - b_bin_reg)
                                             : (2*W)'(b_bin_reg - a_bin_reg);
  assign is_ovf     = (acc_reg >= LIMIT);
  assign conv_start = (state_reg == CONV) && conv_first_reg && !is_ovf;

  bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .abort (key_clr),
    .bin   (acc_reg[W-1:0]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ENTER_A; op_reg <= OP_NONE;
      a_bcd_reg <= '0; a_bin_reg <= '0; b_bcd_reg <= '0; b_bin_reg <= '0;
      acc_reg <= '0; mcand_reg <= '0; mplier_reg <= '0; cnt_reg <= '0;
      neg_reg <= 1'b0; ovf_reg <= 1'b0; rv_reg <= 1'b0; conv_first_reg <= 1'b0;
    end else begin
      rv_reg <= 1'b0;
      if (key_clr) begin
        state_reg <= ENTER_A; op_reg <= OP_NONE;
        a_bcd_reg <= '0; a_bin_reg <= '0; b_bcd_reg <= '0; b_bin_reg <= '0;
        neg_reg <= 1'b0; ovf_reg <= 1'b0; conv_first_reg <= 1'b0;
      end else begin
        case (state_reg)
          ENTER_A: begin
            if (key_digit || key_bksp) begin
              a_bcd_reg <= ed_bcd; a_bin_reg <= ed_bin;
            end else if (key_op) begin
              op_reg <= key_to_op(key_code);
              b_bcd_reg <= '0; b_bin_reg <= '0;
              state_reg <= ENTER_B;
            end
          end
          ENTER_B: begin
            if (key_digit || key_bksp) begin
              b_bcd_reg <= ed_bcd; b_bin_reg <= ed_bin;
            end else if (key_op) begin
              op_reg <= key_to_op(key_code);
            end else if (key_eq) begin
              acc_reg <= '0;
              mcand_reg <= (2*W)'(a_bin_reg);
              mplier_reg <= b_bin_reg;
              cnt_reg <= CW'(W);
              state_reg <= CALC;
            end
          end
          CALC: begin
            if (op_reg == OP_MUL) begin
              acc_reg <= acc_reg + mul_add;
              mcand_reg <= mcand_reg << 1;
              mplier_reg <= mplier_reg >> 1;
              cnt_reg <= cnt_reg - 1'b1;
              if (cnt_reg == CW'(1)) begin
                state_reg <= CONV; conv_first_reg <= 1'b1;
              end
            end else begin
              acc_reg <= (op_reg == OP_SUB) ? diff_res : sum_res;
              neg_reg <= (op_reg == OP_SUB) && (a_bin_reg < b_bin_reg);
              state_reg <= CONV; conv_first_reg <= 1'b1;
            end
          end
          CONV: begin
            conv_first_reg <= 1'b0;
            if (conv_first_reg && is_ovf) begin
              ovf_reg <= 1'b1; rv_reg <= 1'b1; state_reg <= SHOW;
            end else if (conv_done) begin
              rv_reg <= 1'b1; state_reg <= SHOW;
            end
          end
          SHOW: begin
            if (key_digit) begin
              a_bcd_reg <= DW'(key_code); a_bin_reg <= W'(key_code);
              b_bcd_reg <= '0; b_bin_reg <= '0;
              neg_reg <= 1'b0; ovf_reg <= 1'b0; op_reg <= OP_NONE;
              state_reg <= ENTER_A;
            end else if (key_op) begin
              // Chaining only carries a displayable, non-negative result forward.
              if (!neg_reg && !ovf_reg) begin
                a_bcd_reg <= conv_bcd; a_bin_reg <= acc_reg[W-1:0];
              end else begin
                a_bcd_reg <= '0; a_bin_reg <= '0;
              end
              b_bcd_reg <= '0; b_bin_reg <= '0;
              neg_reg <= 1'b0; ovf_reg <= 1'b0;
              op_reg <= key_to_op(key_code);
              state_reg <= ENTER_B;
            end
          end
          default: state_reg <= ENTER_A;
        endcase
      end
    end
  end

  always_comb begin
    case (state_reg)
      ENTER_B, CALC, CONV: disp_bcd = b_bcd_reg;
      SHOW:                disp_bcd = ovf_reg ? '0 : conv_bcd;
      default:             disp_bcd = a_bcd_reg;
    endcase
  end

  assign busy         = (state_reg == CALC) || (state_reg == CONV);
  assign disp_neg     = neg_reg;
  assign overflow     = ovf_reg;
  assign result_valid = rv_reg;
  assign op_ind       = op_reg;

endmodule

// File: tb/tb_bcd_calc_engine.sv
// Directed bench for bcd_calc_engine (NDIG=4, W=14): entry, add/sub/mul, overflow, chaining, CLEAR, reset.
module tb_bcd_calc_engine;
  localparam int NDIG = 4;
  localparam int W    = 14;
  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12;
  localparam logic [3:0] K_EQ = 4'd13, K_CLR = 4'd14, K_BKSP = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        busy, disp_neg, overflow, result_valid;
  logic [15:0] disp_bcd;
  logic [1:0]  op_ind;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, nrv, nbusy;

  always #5 clk = ~clk;

  bcd_calc_engine #(.NDIG(NDIG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .busy         (busy),
    .disp_bcd     (disp_bcd),
    .disp_neg     (disp_neg),
    .overflow     (overflow),
    .result_valid (result_valid),
    .op_ind       (op_ind)
  );

  // One-cycle key strobe; returns at the falling edge after the key was sampled.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic press_seq(input logic [3:0] keys[$]);
    foreach (keys[i]) press(keys[i]);
  endtask

  // Observation index 1 is the cycle right after the EQUAL strobe (cycle t+1).
  task automatic observe(input int ncyc, output int first_rv, output int cnt_rv, output int cnt_busy);
    first_rv = -1; cnt_rv = 0; cnt_busy = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (result_valid) begin
        cnt_rv++;
        if (first_rv < 0) first_rv = i;
      end
      if (busy) cnt_busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy, disp_bcd, disp_neg, overflow, result_valid, op_ind} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_por outputs: got busy=%b disp=%h neg=%b ovf=%b rv=%b op=%b required all 0",
               busy, disp_bcd, disp_neg, overflow, result_valid, op_ind);
    end
    @(negedge clk); rst_n = 1'b1;
    press_seq('{4'd9, 4'd9, K_MUL, 4'd9, 4'd9, K_EQ});
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mul_busy: got %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, disp_bcd, disp_neg, overflow, result_valid, op_ind} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul outputs: got busy=%b disp=%h neg=%b ovf=%b rv=%b op=%b required all 0",
               busy, disp_bcd, disp_neg, overflow, result_valid, op_ind);
    end
    @(negedge clk); rst_n = 1'b1;
    press(4'd7);
    n_checks++;
    if ({busy, disp_bcd} !== {1'b0, 16'h0007}) begin
      n_fail++; $display("FAIL reset_enter_a: got busy=%b disp=%h required 0 0007", busy, disp_bcd);
    end
    $display("reset: mid-multiply reset -> busy=%b disp=%h op=%b", busy, disp_bcd, op_ind);
  endtask

  task automatic test_add;
    press_seq('{K_CLR, 4'd1, 4'd2, 4'd3, 4'd4, K_ADD, 4'd8, 4'd7, 4'd6, 4'd5, K_EQ});
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if ({disp_bcd, overflow, disp_neg} !== {16'h9999, 2'b00}) begin
      n_fail++; $display("FAIL add_9999 value: got disp=%h ovf=%b neg=%b required 9999 0 0", disp_bcd, overflow, disp_neg);
    end
    n_checks++;
    if (lat !== W + 2 || nrv !== 1) begin
      n_fail++; $display("FAIL add_latency: got lat=%0d pulses=%0d required lat=%0d pulses=1", lat, nrv, W + 2);
    end
    n_checks++;
    if (nbusy !== W + 1 || op_ind !== 2'b01) begin
      n_fail++; $display("FAIL add_busy_op: got busy_cycles=%0d op=%b required %0d 01", nbusy, op_ind, W + 1);
    end
    $display("add 1234+8765: disp=%h ovf=%b lat=%0d busy_cycles=%0d", disp_bcd, overflow, lat, nbusy);

    press_seq('{K_CLR, 4'd9, 4'd9, 4'd9, 4'd9, K_ADD, 4'd1, K_EQ});
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if ({disp_bcd, overflow} !== {16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL add_overflow value: got disp=%h ovf=%b required 0000 1", disp_bcd, overflow);
    end
    n_checks++;
    if (lat !== 3 || nrv !== 1) begin
      n_fail++; $display("FAIL add_overflow_latency: got lat=%0d pulses=%0d required lat=3 pulses=1", lat, nrv);
    end
    $display("add 9999+1: disp=%h ovf=%b lat=%0d", disp_bcd, overflow, lat);
  endtask

  task automatic test_sub_chain;
    press_seq('{K_CLR, 4'd2, 4'd5, K_SUB, 4'd3, 4'd0, 4'd0, K_EQ});
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if ({disp_bcd, disp_neg, overflow} !== {16'h0275, 2'b10}) begin
      n_fail++; $display("FAIL sub_neg value: got disp=%h neg=%b ovf=%b required 0275 1 0", disp_bcd, disp_neg, overflow);
    end
    n_checks++;
    if (lat !== W + 2 || op_ind !== 2'b10) begin
      n_fail++; $display("FAIL sub_latency_op: got lat=%0d op=%b required %0d 10", lat, op_ind, W + 2);
    end
    $display("sub 25-300: disp=%h neg=%b lat=%0d", disp_bcd, disp_neg, lat);
    press_seq('{K_ADD, 4'd5, K_EQ});
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if ({disp_bcd, disp_neg, op_ind} !== {16'h0005, 1'b0, 2'b01}) begin
      n_fail++; $display("FAIL chain_after_neg: got disp=%h neg=%b op=%b required 0005 0 01", disp_bcd, disp_neg, op_ind);
    end
    $display("chain neg->ADD 5: disp=%h neg=%b", disp_bcd, disp_neg);
  endtask

  task automatic test_mul;
    press_seq('{K_CLR, 4'd9, 4'd9, K_MUL, 4'd9, 4'd9, K_EQ});
    observe(60, lat, nrv, nbusy);
    n_checks++;
    if (disp_bcd !== 16'h9801 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mul_value: got disp=%h ovf=%b required 9801 0", disp_bcd, overflow);
    end
    n_checks++;
    if (lat !== 2 * W + 1 || nbusy !== 2 * W || nrv !== 1) begin
      n_fail++; $display("FAIL mul_timing: got lat=%0d busy_cycles=%0d pulses=%0d required %0d %0d 1",
                         lat, nbusy, nrv, 2 * W + 1, 2 * W);
    end
    $display("mul 99*99: disp=%h lat=%0d busy_cycles=%0d", disp_bcd, lat, nbusy);
    press_seq('{K_MUL, 4'd2, K_EQ});
    observe(60, lat, nrv, nbusy);
    n_checks++;
    if ({disp_bcd, overflow, op_ind} !== {16'h0000, 1'b1, 2'b11}) begin
      n_fail++; $display("FAIL mul_overflow: got disp=%h ovf=%b op=%b required 0000 1 11", disp_bcd, overflow, op_ind);
    end
    n_checks++;
    if (lat !== W + 2) begin
      n_fail++; $display("FAIL mul_overflow_latency: got %0d required %0d", lat, W + 2);
    end
    $display("mul 9801*2: disp=%h ovf=%b lat=%0d", disp_bcd, overflow, lat);
    press(4'd7);
    n_checks++;
    if ({disp_bcd, overflow, op_ind} !== {16'h0007, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL show_digit: got disp=%h ovf=%b op=%b required 0007 0 00", disp_bcd, overflow, op_ind);
    end
    $display("digit after result: disp=%h ovf=%b op=%b", disp_bcd, overflow, op_ind);
  endtask

  task automatic test_entry;
    press_seq('{K_CLR, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    n_checks++;
    if (disp_bcd !== 16'h1234) begin
      n_fail++; $display("FAIL entry_full: got %h required 1234", disp_bcd);
    end
    press(K_BKSP);
    n_checks++;
    if (disp_bcd !== 16'h0123) begin
      n_fail++; $display("FAIL entry_bksp: got %h required 0123", disp_bcd);
    end
    press_seq('{K_ADD, 4'd7, K_EQ});
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if (disp_bcd !== 16'h0130) begin
      n_fail++; $display("FAIL entry_bksp_binary: got %h required 0130", disp_bcd);
    end
    $display("entry 12345,BKSP then +7: disp=%h", disp_bcd);
  endtask

  task automatic test_busy_keys;
    press_seq('{K_CLR, 4'd1, K_ADD, 4'd2, K_EQ});
    press(4'd5);
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if (disp_bcd !== 16'h0003 || nrv !== 1) begin
      n_fail++; $display("FAIL busy_digit: got disp=%h pulses=%0d required 0003 1", disp_bcd, nrv);
    end
    press_seq('{K_ADD, 4'd1, K_EQ});
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if (disp_bcd !== 16'h0004) begin
      n_fail++; $display("FAIL busy_digit_chain: got %h required 0004", disp_bcd);
    end
    $display("digit while busy ignored: 1+2 -> then +1 -> disp=%h", disp_bcd);
  endtask

  task automatic test_clear_conv;
    press_seq('{K_CLR, 4'd1, K_ADD, 4'd2, K_EQ});
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL clear_pre_busy: got %b required 1", busy);
    end
    press(K_CLR);
    n_checks++;
    if ({busy, disp_bcd, op_ind, overflow, disp_neg} !== 21'd0) begin
      n_fail++; $display("FAIL clear_conv state: got busy=%b disp=%h op=%b ovf=%b neg=%b required all 0",
                         busy, disp_bcd, op_ind, overflow, disp_neg);
    end
    observe(40, lat, nrv, nbusy);
    n_checks++;
    if (nrv !== 0 || nbusy !== 0) begin
      n_fail++; $display("FAIL clear_conv no_result: got pulses=%0d busy_cycles=%0d required 0 0", nrv, nbusy);
    end
    $display("CLEAR during CONV: busy=%b disp=%h pulses=%0d", busy, disp_bcd, nrv);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_sub_chain();
    test_mul();
    test_entry();
    test_busy_keys();
    test_clear_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
